// File: rtl/ofs_plat_avalon_mem_rdwr_arb2.sv
// Two-source arbiter for one Avalon split-bus read/write sink. Read and write
// channels use independent round-robin; write bursts stay atomic.
module ofs_plat_avalon_mem_rdwr_arb2 #(
  parameter int ADDR_WIDTH      = 32,
  parameter int DATA_WIDTH      = 512,
  parameter int BURST_CNT_WIDTH = 7,
  parameter int MAX_OUTSTANDING = 64
) (
  input  logic                         clk,
  input  logic                         reset,

  input  logic                         s0_rd_read,
  input  logic [ADDR_WIDTH-1:0]        s0_rd_address,
  input  logic [BURST_CNT_WIDTH-1:0]   s0_rd_burstcount,
  input  logic [DATA_WIDTH/8-1:0]      s0_rd_byteenable,
  output logic                         s0_rd_waitrequest,
  output logic                         s0_rd_readdatavalid,
  output logic [DATA_WIDTH-1:0]        s0_rd_readdata,
  output logic [1:0]                   s0_rd_response,
  input  logic                         s0_wr_write,
  input  logic [ADDR_WIDTH-1:0]        s0_wr_address,
  input  logic [BURST_CNT_WIDTH-1:0]   s0_wr_burstcount,
  input  logic [DATA_WIDTH-1:0]        s0_wr_writedata,
  input  logic [DATA_WIDTH/8-1:0]      s0_wr_byteenable,
  output logic                         s0_wr_waitrequest,
  output logic                         s0_wr_writeresponsevalid,
  output logic [1:0]                   s0_wr_response,

  input  logic                         s1_rd_read,
  input  logic [ADDR_WIDTH-1:0]        s1_rd_address,
  input  logic [BURST_CNT_WIDTH-1:0]   s1_rd_burstcount,
  input  logic [DATA_WIDTH/8-1:0]      s1_rd_byteenable,
  output logic                         s1_rd_waitrequest,
  output logic                         s1_rd_readdatavalid,
  output logic [DATA_WIDTH-1:0]        s1_rd_readdata,
  output logic [1:0]                   s1_rd_response,
  input  logic                         s1_wr_write,
  input  logic [ADDR_WIDTH-1:0]        s1_wr_address,
  input  logic [BURST_CNT_WIDTH-1:0]   s1_wr_burstcount,
  input  logic [DATA_WIDTH-1:0]        s1_wr_writedata,
  input  logic [DATA_WIDTH/8-1:0]      s1_wr_byteenable,
  output logic                         s1_wr_waitrequest,
  output logic                         s1_wr_writeresponsevalid,
  output logic [1:0]                   s1_wr_response,

  output logic                         m_rd_read,
  output logic [ADDR_WIDTH-1:0]        m_rd_address,
  output logic [BURST_CNT_WIDTH-1:0]   m_rd_burstcount,
  output logic [DATA_WIDTH/8-1:0]      m_rd_byteenable,
  input  logic                         m_rd_waitrequest,
  input  logic                         m_rd_readdatavalid,
  input  logic [DATA_WIDTH-1:0]        m_rd_readdata,
  input  logic [1:0]                   m_rd_response,
  output logic                         m_wr_write,
  output logic [ADDR_WIDTH-1:0]        m_wr_address,
  output logic [BURST_CNT_WIDTH-1:0]   m_wr_burstcount,
  output logic [DATA_WIDTH-1:0]        m_wr_writedata,
  output logic [DATA_WIDTH/8-1:0]      m_wr_byteenable,
  input  logic                         m_wr_waitrequest,
  input  logic                         m_wr_writeresponsevalid,
  input  logic [1:0]                   m_wr_response
);

  localparam int TAG_AW = $clog2(MAX_OUTSTANDING);
  localparam logic [TAG_AW:0] TAG_DEPTH = (TAG_AW+1)'(MAX_OUTSTANDING);
  localparam logic [0:0] WR_IDLE  = 1'b0;
  localparam logic [0:0] WR_BURST = 1'b1;

  logic                        prio_rd, grant_rd, rd_accept, rd_push, rd_pop, rd_beat;
  logic                        rd_tag_full, rd_empty, rd_beat_last;
  logic [BURST_CNT_WIDTH:0]    rd_tag_mem [MAX_OUTSTANDING];
  logic [BURST_CNT_WIDTH:0]    rd_head;
  logic [TAG_AW-1:0]           rd_wptr, rd_rptr;
  logic [TAG_AW:0]             rd_cnt;
  logic [BURST_CNT_WIDTH-1:0]  rd_beat_cnt;
  logic [DATA_WIDTH-1:0]       rd_data_q;
  logic [1:0]                  rd_resp_q, wr_resp_q;

  logic                        prio_wr, grant_wr, wr_sel_req, wr_accept, wr_push, wr_pop;
  logic                        wr_tag_full, wr_empty, lock_src;
  logic [0:0]                  wr_state;
  logic                        wr_tag_mem [MAX_OUTSTANDING];
  logic [TAG_AW-1:0]           wr_wptr, wr_rptr;
  logic [TAG_AW:0]             wr_cnt;
  logic [BURST_CNT_WIDTH-1:0]  beats_left;

  // Read command path: zero-cycle mux toward the sink
  always_comb begin
    if (s0_rd_read && s1_rd_read) grant_rd = prio_rd;
    else                          grant_rd = s1_rd_read;
  end

  assign rd_tag_full       = (rd_cnt == TAG_DEPTH);
  assign rd_empty          = (rd_cnt == '0);
  assign m_rd_read         = !reset && (s0_rd_read || s1_rd_read) && !rd_tag_full;
  assign m_rd_address      = grant_rd ? s1_rd_address    : s0_rd_address;
  assign m_rd_burstcount   = grant_rd ? s1_rd_burstcount : s0_rd_burstcount;
  assign m_rd_byteenable   = grant_rd ? s1_rd_byteenable : s0_rd_byteenable;
  assign s0_rd_waitrequest = !(m_rd_read && !grant_rd) || m_rd_waitrequest;
  assign s1_rd_waitrequest = !(m_rd_read &&  grant_rd) || m_rd_waitrequest;
  assign rd_accept         = m_rd_read && !m_rd_waitrequest;
  assign rd_push           = rd_accept;

  assign rd_head      = rd_tag_mem[rd_rptr];
  assign rd_beat      = m_rd_readdatavalid && !rd_empty;
  assign rd_beat_last = ((rd_beat_cnt + BURST_CNT_WIDTH'(1)) == rd_head[BURST_CNT_WIDTH-1:0]);
  assign rd_pop       = rd_beat && rd_beat_last;

  // Write command path; a burst in flight owns the channel regardless of tag space
  always_comb begin
    if (wr_state == WR_BURST)           grant_wr = lock_src;
    else if (s0_wr_write && s1_wr_write) grant_wr = prio_wr;
    else                                 grant_wr = s1_wr_write;
  end

  assign wr_tag_full       = (wr_cnt == TAG_DEPTH);
  assign wr_empty          = (wr_cnt == '0);
  assign wr_sel_req        = grant_wr ? s1_wr_write : s0_wr_write;
  assign m_wr_write        = !reset && wr_sel_req && ((wr_state == WR_BURST) || !wr_tag_full);
  assign m_wr_address      = grant_wr ? s1_wr_address    : s0_wr_address;
  assign m_wr_burstcount   = grant_wr ? s1_wr_burstcount : s0_wr_burstcount;
  assign m_wr_writedata    = grant_wr ? s1_wr_writedata  : s0_wr_writedata;
  assign m_wr_byteenable   = grant_wr ? s1_wr_byteenable : s0_wr_byteenable;
  assign s0_wr_waitrequest = !(m_wr_write && !grant_wr) || m_wr_waitrequest;
  assign s1_wr_waitrequest = !(m_wr_write &&  grant_wr) || m_wr_waitrequest;
  assign wr_accept         = m_wr_write && !m_wr_waitrequest;
  assign wr_push           = wr_accept && (wr_state == WR_IDLE);
  assign wr_pop            = m_wr_writeresponsevalid && !wr_empty;

  always_ff @(posedge clk) begin
    if (rd_push) rd_tag_mem[rd_wptr] <= {grant_rd, m_rd_burstcount};
    if (wr_push) wr_tag_mem[wr_wptr] <= grant_wr;
    rd_data_q <= m_rd_readdata;
    rd_resp_q <= m_rd_response;
    wr_resp_q <= m_wr_response;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      prio_rd     <= 1'b0;
      rd_wptr     <= '0;
      rd_rptr     <= '0;
      rd_cnt      <= '0;
      rd_beat_cnt <= '0;
      s0_rd_readdatavalid <= 1'b0;
      s1_rd_readdatavalid <= 1'b0;
    end else begin
      if (rd_accept) prio_rd <= !grant_rd;
      if (rd_push) rd_wptr <= rd_wptr + TAG_AW'(1);
      if (rd_pop)  rd_rptr <= rd_rptr + TAG_AW'(1);
      if (rd_push && !rd_pop)      rd_cnt <= rd_cnt + (TAG_AW+1)'(1);
      else if (!rd_push && rd_pop) rd_cnt <= rd_cnt - (TAG_AW+1)'(1);
      if (rd_beat) rd_beat_cnt <= rd_beat_last ? '0 : rd_beat_cnt + BURST_CNT_WIDTH'(1);
      s0_rd_readdatavalid <= rd_beat && !rd_head[BURST_CNT_WIDTH];
      s1_rd_readdatavalid <= rd_beat &&  rd_head[BURST_CNT_WIDTH];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_state   <= WR_IDLE;
      prio_wr    <= 1'b0;
      lock_src   <= 1'b0;
      beats_left <= '0;
      wr_wptr    <= '0;
      wr_rptr    <= '0;
      wr_cnt     <= '0;
      s0_wr_writeresponsevalid <= 1'b0;
      s1_wr_writeresponsevalid <= 1'b0;
    end else begin
      if (wr_state == WR_IDLE) begin
        if (wr_push) begin
          if (m_wr_burstcount > BURST_CNT_WIDTH'(1)) begin
            wr_state   <= WR_BURST;
            lock_src   <= grant_wr;
            beats_left <= m_wr_burstcount - BURST_CNT_WIDTH'(1);
          end else begin
            prio_wr <= !prio_wr;
          end
        end
      end else if (wr_accept) begin
        beats_left <= beats_left - BURST_CNT_WIDTH'(1);
        if (beats_left == BURST_CNT_WIDTH'(1)) begin
          wr_state <= WR_IDLE;
          prio_wr  <= !prio_wr;
        end
      end
      if (wr_push) wr_wptr <= wr_wptr + TAG_AW'(1);
      if (wr_pop)  wr_rptr <= wr_rptr + TAG_AW'(1);
      if (wr_push && !wr_pop)      wr_cnt <= wr_cnt + (TAG_AW+1)'(1);
      else if (!wr_push && wr_pop) wr_cnt <= wr_cnt - (TAG_AW+1)'(1);
      s0_wr_writeresponsevalid <= wr_pop && !wr_tag_mem[wr_rptr];
      s1_wr_writeresponsevalid <= wr_pop &&  wr_tag_mem[wr_rptr];
    end
  end

  assign s0_rd_readdata = rd_data_q;
  assign s1_rd_readdata = rd_data_q;
  assign s0_rd_response = rd_resp_q;
  assign s1_rd_response = rd_resp_q;
  assign s0_wr_response = wr_resp_q;
  assign s1_wr_response = wr_resp_q;

  // Protocol checks: orphan responses are dropped above but stop simulation here
  always @(posedge clk) begin
    if (!reset) begin
      assert (!(m_rd_readdatavalid && rd_empty)) else $fatal(1, "read response with no outstanding read tag");
      assert (!(m_wr_writeresponsevalid && wr_empty)) else $fatal(1, "write response with no outstanding write tag");
      if (rd_accept) assert (m_rd_burstcount != '0) else $error("read accepted with burstcount 0");
      if (wr_push)   assert (m_wr_burstcount != '0) else $error("write accepted with burstcount 0");
    end
  end

endmodule

// File: tb/tb_ofs_plat_avalon_mem_rdwr_arb2.sv
// Directed bench for the two-source Avalon read/write arbiter.
module tb_ofs_plat_avalon_mem_rdwr_arb2;
  localparam int AW = 32, DW = 32, BW = 7, MO = 8, BEW = DW/8;

  logic clk = 1'b0, reset = 1'b1;
  logic s0_rd_read = 0, s1_rd_read = 0, s0_wr_write = 0, s1_wr_write = 0;
  logic [AW-1:0] s0_rd_address = '0, s1_rd_address = '0, s0_wr_address = '0, s1_wr_address = '0;
  logic [BW-1:0] s0_rd_burstcount = 1, s1_rd_burstcount = 1, s0_wr_burstcount = 1, s1_wr_burstcount = 1;
  logic [BEW-1:0] s0_rd_byteenable = '1, s1_rd_byteenable = '1, s0_wr_byteenable = '1, s1_wr_byteenable = '1;
  logic [DW-1:0] s0_wr_writedata = '0, s1_wr_writedata = '0;
  logic s0_rd_waitrequest, s1_rd_waitrequest, s0_wr_waitrequest, s1_wr_waitrequest;
  logic s0_rd_readdatavalid, s1_rd_readdatavalid, s0_wr_writeresponsevalid, s1_wr_writeresponsevalid;
  logic [DW-1:0] s0_rd_readdata, s1_rd_readdata;
  logic [1:0] s0_rd_response, s1_rd_response, s0_wr_response, s1_wr_response;
  logic m_rd_read, m_wr_write;
  logic [AW-1:0] m_rd_address, m_wr_address;
  logic [BW-1:0] m_rd_burstcount, m_wr_burstcount;
  logic [BEW-1:0] m_rd_byteenable, m_wr_byteenable;
  logic [DW-1:0] m_wr_writedata;
  logic m_rd_waitrequest = 0, m_wr_waitrequest = 0, m_rd_readdatavalid = 0, m_wr_writeresponsevalid = 0;
  logic [DW-1:0] m_rd_readdata = '0;
  logic [1:0] m_rd_response = '0, m_wr_response = '0;

  int n_cmp = 0, n_err = 0;
  int acc0, acc1;

  ofs_plat_avalon_mem_rdwr_arb2 #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .BURST_CNT_WIDTH(BW), .MAX_OUTSTANDING(MO)) dut (
    .clk(clk), .reset(reset),
    .s0_rd_read(s0_rd_read), .s0_rd_address(s0_rd_address), .s0_rd_burstcount(s0_rd_burstcount),
    .s0_rd_byteenable(s0_rd_byteenable), .s0_rd_waitrequest(s0_rd_waitrequest),
    .s0_rd_readdatavalid(s0_rd_readdatavalid), .s0_rd_readdata(s0_rd_readdata), .s0_rd_response(s0_rd_response),
    .s0_wr_write(s0_wr_write), .s0_wr_address(s0_wr_address), .s0_wr_burstcount(s0_wr_burstcount),
    .s0_wr_writedata(s0_wr_writedata), .s0_wr_byteenable(s0_wr_byteenable), .s0_wr_waitrequest(s0_wr_waitrequest),
    .s0_wr_writeresponsevalid(s0_wr_writeresponsevalid), .s0_wr_response(s0_wr_response),
    .s1_rd_read(s1_rd_read), .s1_rd_address(s1_rd_address), .s1_rd_burstcount(s1_rd_burstcount),
    .s1_rd_byteenable(s1_rd_byteenable), .s1_rd_waitrequest(s1_rd_waitrequest),
    .s1_rd_readdatavalid(s1_rd_readdatavalid), .s1_rd_readdata(s1_rd_readdata), .s1_rd_response(s1_rd_response),
    .s1_wr_write(s1_wr_write), .s1_wr_address(s1_wr_address), .s1_wr_burstcount(s1_wr_burstcount),
    .s1_wr_writedata(s1_wr_writedata), .s1_wr_byteenable(s1_wr_byteenable), .s1_wr_waitrequest(s1_wr_waitrequest),
    .s1_wr_writeresponsevalid(s1_wr_writeresponsevalid), .s1_wr_response(s1_wr_response),
    .m_rd_read(m_rd_read), .m_rd_address(m_rd_address), .m_rd_burstcount(m_rd_burstcount),
    .m_rd_byteenable(m_rd_byteenable), .m_rd_waitrequest(m_rd_waitrequest),
    .m_rd_readdatavalid(m_rd_readdatavalid), .m_rd_readdata(m_rd_readdata), .m_rd_response(m_rd_response),
    .m_wr_write(m_wr_write), .m_wr_address(m_wr_address), .m_wr_burstcount(m_wr_burstcount),
    .m_wr_writedata(m_wr_writedata), .m_wr_byteenable(m_wr_byteenable), .m_wr_waitrequest(m_wr_waitrequest),
    .m_wr_writeresponsevalid(m_wr_writeresponsevalid), .m_wr_response(m_wr_response)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    tick();
  endtask

  initial begin
    // Reset values, with a source requesting to show the gating
    s0_rd_read = 1; s1_wr_write = 1;
    #2;
    chk("rst s0_rd_wait", s0_rd_waitrequest, 1);
    chk("rst s1_rd_wait", s1_rd_waitrequest, 1);
    chk("rst s0_wr_wait", s0_wr_waitrequest, 1);
    chk("rst s1_wr_wait", s1_wr_waitrequest, 1);
    chk("rst m_rd_read", m_rd_read, 0);
    chk("rst m_wr_write", m_wr_write, 0);
    chk("rst valids", {s0_rd_readdatavalid, s1_rd_readdatavalid, s0_wr_writeresponsevalid, s1_wr_writeresponsevalid}, 0);
    s0_rd_read = 0; s1_wr_write = 0;
    do_reset();

    // Single 4-beat read from s0
    s0_rd_read = 1; s0_rd_address = 32'h100; s0_rd_burstcount = 4;
    #1;
    chk("t1 m_rd_read", m_rd_read, 1);
    chk("t1 s0 wait", s0_rd_waitrequest, 0);
    chk("t1 m_rd_address", m_rd_address, 32'h100);
    chk("t1 m_rd_burstcount", m_rd_burstcount, 4);
    tick();
    s0_rd_read = 0;
    for (int i = 0; i < 4; i++) begin
      m_rd_readdatavalid = 1; m_rd_readdata = 32'hA0 + i;
      tick();
      chk("t1 s0 rdv", s0_rd_readdatavalid, 1);
      chk("t1 s0 data", s0_rd_readdata, 32'hA0 + i);
      chk("t1 s1 rdv", s1_rd_readdatavalid, 0);
    end
    m_rd_readdatavalid = 0;
    tick();
    chk("t1 s0 rdv end", s0_rd_readdatavalid, 0);
    chk("t1 fifo empty", dut.rd_cnt, 0);

    // Read contention: alternating grants from s0 after reset
    do_reset();
    s0_rd_read = 1; s0_rd_address = 32'h200; s0_rd_burstcount = 1;
    s1_rd_read = 1; s1_rd_address = 32'h300; s1_rd_burstcount = 1;
    acc0 = 0; acc1 = 0;
    for (int i = 0; i < 8; i++) begin
      #1;
      chk("t2 s0 wait", s0_rd_waitrequest, (i % 2 == 1));
      chk("t2 s1 wait", s1_rd_waitrequest, (i % 2 == 0));
      chk("t2 m_rd_address", m_rd_address, (i % 2 == 1) ? 32'h300 : 32'h200);
      if (!s0_rd_waitrequest) acc0++;
      if (!s1_rd_waitrequest) acc1++;
      tick();
    end
    chk("t2 s0 accepts", acc0, 4);
    chk("t2 s1 accepts", acc1, 4);
    s0_rd_read = 0; s1_rd_read = 0;
    for (int i = 0; i < 8; i++) begin
      m_rd_readdatavalid = 1; m_rd_readdata = 32'h10 + i;
      tick();
      chk("t2 s0 rdv route", s0_rd_readdatavalid, (i % 2 == 0));
      chk("t2 s1 rdv route", s1_rd_readdatavalid, (i % 2 == 1));
    end
    m_rd_readdatavalid = 0;
    tick();

    // Sink back-pressure during contention: nothing accepted, priority holds
    s0_rd_read = 1; s1_rd_read = 1; m_rd_waitrequest = 1;
    for (int i = 0; i < 5; i++) begin
      #1;
      chk("t5 s0 wait", s0_rd_waitrequest, 1);
      chk("t5 s1 wait", s1_rd_waitrequest, 1);
      chk("t5 m_rd_read", m_rd_read, 1);
      chk("t5 m_rd_address", m_rd_address, 32'h200);
      tick();
    end
    m_rd_waitrequest = 0;
    #1;
    chk("t5 s0 granted", s0_rd_waitrequest, 0);
    tick();
    s0_rd_read = 0;
    #1;
    chk("t5 s1 granted", s1_rd_waitrequest, 0);
    tick();
    s1_rd_read = 0;
    m_rd_readdatavalid = 1;
    tick();
    chk("t5 resp0 s0", s0_rd_readdatavalid, 1);
    tick();
    chk("t5 resp1 s1", s1_rd_readdatavalid, 1);
    m_rd_readdatavalid = 0;
    tick();

    // Tag FIFO full blocks the next read until a pop
    do_reset();
    s0_rd_read = 1; s0_rd_address = 32'h400; s0_rd_burstcount = 1;
    for (int i = 0; i < MO; i++) begin
      #1;
      chk("t4 fill wait", s0_rd_waitrequest, 0);
      tick();
    end
    #1;
    chk("t4 full wait", s0_rd_waitrequest, 1);
    chk("t4 full m_rd_read", m_rd_read, 0);
    m_rd_readdatavalid = 1; m_rd_readdata = 32'h55;
    #1;
    chk("t4 pop cycle wait", s0_rd_waitrequest, 1);
    tick();
    m_rd_readdatavalid = 0;
    #1;
    chk("t4 after pop wait", s0_rd_waitrequest, 0);
    chk("t4 after pop m_rd_read", m_rd_read, 1);
    chk("t4 resp s0", s0_rd_readdatavalid, 1);
    chk("t4 resp data", s0_rd_readdata, 32'h55);
    tick();
    s0_rd_read = 0;
    do_reset();

    // Atomic 3-beat write burst from s1 while s0 waits
    s1_wr_write = 1; s1_wr_address = 32'h500; s1_wr_burstcount = 3; s1_wr_writedata = 32'hD0;
    #1;
    chk("t3 beat1 s1 wait", s1_wr_waitrequest, 0);
    chk("t3 beat1 m_wr_write", m_wr_write, 1);
    tick();
    s0_wr_write = 1; s0_wr_address = 32'h580; s0_wr_burstcount = 1; s0_wr_writedata = 32'hE0;
    s1_wr_writedata = 32'hD1;
    #1;
    chk("t3 beat2 s0 wait", s0_wr_waitrequest, 1);
    chk("t3 beat2 s1 wait", s1_wr_waitrequest, 0);
    chk("t3 beat2 data", m_wr_writedata, 32'hD1);
    tick();
    s1_wr_writedata = 32'hD2;
    #1;
    chk("t3 beat3 s0 wait", s0_wr_waitrequest, 1);
    chk("t3 beat3 s1 wait", s1_wr_waitrequest, 0);
    chk("t3 beat3 data", m_wr_writedata, 32'hD2);
    tick();
    s1_wr_write = 0;
    #1;
    chk("t3 s0 granted", s0_wr_waitrequest, 0);
    chk("t3 s0 addr", m_wr_address, 32'h580);
    tick();
    s0_wr_write = 0;
    m_wr_writeresponsevalid = 1;
    tick();
    chk("t3 resp1 s1", s1_wr_writeresponsevalid, 1);
    chk("t3 resp1 s0", s0_wr_writeresponsevalid, 0);
    tick();
    chk("t3 resp2 s0", s0_wr_writeresponsevalid, 1);
    chk("t3 resp2 s1", s1_wr_writeresponsevalid, 0);
    m_wr_writeresponsevalid = 0;
    tick();
    chk("t3 resp idle", {s0_wr_writeresponsevalid, s1_wr_writeresponsevalid}, 0);

    // Reset in the middle of a write burst
    s0_wr_write = 1; s0_wr_address = 32'h600; s0_wr_burstcount = 3;
    #1;
    chk("t6 first beat wait", s0_wr_waitrequest, 0);
    tick();
    chk("t6 beats_left", dut.beats_left, 2);
    reset = 1;
    #1;
    chk("t6 rst s0 wr wait", s0_wr_waitrequest, 1);
    chk("t6 rst s1 wr wait", s1_wr_waitrequest, 1);
    chk("t6 rst m_wr_write", m_wr_write, 0);
    chk("t6 rst state idle", dut.wr_state, 0);
    chk("t6 rst rd waits", {s0_rd_waitrequest, s1_rd_waitrequest}, 2'b11);
    s0_wr_write = 0;
    tick();
    reset = 0;
    s0_wr_write = 1; s0_wr_address = 32'h700; s0_wr_burstcount = 1;
    #1;
    chk("t6 single wait", s0_wr_waitrequest, 0);
    chk("t6 single m_wr_write", m_wr_write, 1);
    tick();
    s0_wr_write = 0;
    m_wr_writeresponsevalid = 1;
    tick();
    chk("t6 resp s0", s0_wr_writeresponsevalid, 1);
    chk("t6 resp s1", s1_wr_writeresponsevalid, 0);
    m_wr_writeresponsevalid = 0;
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/ofs_plat_avalon_mem_rdwr_arb2.md
# ofs_plat_avalon_mem_rdwr_arb2

Two-to-one arbiter that shares a single Avalon split-bus read/write memory sink, such as a clock-crossing shim's source side, between two requesting sources on one clock. Read and write channels are arbitrated independently with round-robin priority, and write bursts are kept atomic. Response routing is tracked in per-channel tag FIFOs, so read data and write responses return to the issuing source in order.

## Interface
- ADDR_WIDTH, 32, word address width
- DATA_WIDTH, 512, data width; byteenable width is DATA_WIDTH/8
- BURST_CNT_WIDTH, 7, burstcount width
- MAX_OUTSTANDING, 64, read-burst and write-burst tag FIFO depth (power of 2)
- clk  in  1  single clock for all ports
- reset  in  1  asynchronous, active-high reset
- sN_rd_read / sN_rd_address / sN_rd_burstcount / sN_rd_byteenable  in  1 / ADDR_WIDTH / BURST_CNT_WIDTH / DATA_WIDTH/8  source N read command (N = 0, 1)
- sN_rd_waitrequest  out  1  read back-pressure to source N
- sN_rd_readdatavalid / sN_rd_readdata / sN_rd_response  out  1 / DATA_WIDTH / 2  read response to source N
- sN_wr_write / sN_wr_address / sN_wr_burstcount / sN_wr_writedata / sN_wr_byteenable  in  per-field widths  write beat from source N
- sN_wr_waitrequest  out  1  write back-pressure to source N
- sN_wr_writeresponsevalid / sN_wr_response  out  1 / 2  write response to source N
- m_rd_* and m_wr_*  out/in  mirror of the source fields toward the shared sink; m_rd_waitrequest, m_wr_waitrequest, m_rd_readdatavalid, m_rd_readdata, m_rd_response, m_wr_writeresponsevalid and m_wr_response are inputs

## Operation
- A command is accepted when sN_x_valid && !sN_x_waitrequest, where valid is rd_read or wr_write.
- Read arbitration:
  - grant_rd is computed combinationally from the requests and the priority pointer prio_rd.
  - sN_rd_waitrequest = !(grant_rd==N) || m_rd_waitrequest || rd_tag_full.
  - The m_rd_* command fields are muxed from the granted source. m_rd_read is forced to 0 when the tag FIFO is full.
  - On each accepted read, prio_rd points to the other source.
  - Each accepted read pushes the tag {src, burstcount}.
- Read responses:
  - A beat counter tracks the head tag.
  - On each m_rd_readdatavalid the beat is routed to the head src. When the count reaches burstcount the counter is cleared and the tag is popped.
- Write arbitration:
  - States: IDLE and BURST.
  - In IDLE, grant_wr is round-robin (prio_wr), with the same waitrequest rule using wr_tag_full.
  - An accepted first beat pushes the tag {src}. If burstcount > 1, the FSM enters BURST with lock_src = src and beats_left = burstcount-1.
  - In BURST, the grant is fixed to lock_src, the other source sees waitrequest = 1, and wr_tag_full is ignored. Each accepted beat decrements beats_left; the FSM returns to IDLE when the last beat is accepted.
  - prio_wr toggles on burst completion.
- Write responses: each m_wr_writeresponsevalid pops one tag and is routed to its src.
- Response outputs are registered. Non-selected outputs have valid = 0; data is don't-care.
- Tag FIFO full/empty:
  - A push is blocked when the FIFO is full, even if a pop occurs in the same cycle.
  - A simultaneous push and pop when not full leaves the occupancy unchanged.
- A response arriving while the tag FIFO is empty is a protocol error: the beat is dropped, and simulation raises $fatal.
- burstcount == 0 is illegal and is flagged by a simulation assertion.
- Reset mid-operation clears all state. Outstanding sink responses are not tracked after reset, and the environment resets the sink together with this block.

## Timing
- Reset values:
  - All sN_*valid outputs, m_rd_read and m_wr_write are 0.
  - All sN_*waitrequest outputs are 1.
  - prio_rd = prio_wr = 0, FSM = IDLE, counters and FIFOs are empty.
- Command path is combinational; source to sink adds zero cycles.
- Response path adds 1 cycle: sN_rd_readdatavalid follows m_rd_readdatavalid by one clock, as do the data and response. Write responses have the same latency.
- When both sources request in the same cycle, the source indicated by prio wins.
- The sink may respond in the same cycle a tag is pushed only if the tag is already at the head. The bench does not require same-cycle response.

## Test plan
- Single read from s0, burstcount 4, sink returns 4 beats with data 0xA0..0xA3 -> s0 sees 4 valids one cycle later with the same data; s1 sees none; the tag FIFO ends empty.
- Both sources assert read every cycle for 8 cycles with no backpressure -> grants alternate s0, s1, s0, … starting with s0 after reset; 4 accepts each.
- s1 starts a write burst of 3 while s0 holds a single write -> s0 waitrequest stays 1 until s1's 3rd beat is accepted, then s0 is granted the next cycle; responses return as s1 then s0.
- Issue MAX_OUTSTANDING single reads with no responses -> the (MAX_OUTSTANDING+1)th sees waitrequest = 1 and m_rd_read = 0. One response pops the FIFO, and the blocked read is accepted the cycle after the pop.
- m_rd_waitrequest held 1 for 5 cycles during contention -> no accepts, prio unchanged, commands stable at m_rd_*.
- Assert reset mid-write-burst with beats_left = 2 -> all outputs return to reset values asynchronously; after release, an s0 single write is accepted in IDLE.
